// File: rtl/count_cond_pkg.sv
// Shared types and sizing helpers for the count-enable conditioner.
package count_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } cond_state_t;

  // Bits needed to hold values 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int unsigned db, input int unsigned rd,
                                   input int unsigned rp);
    return (db >= 1) && (rd >= 1) && (rp >= 1);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus debounce counter; emits the accepted level and
// single-cycle strobes that line up with the edge where the level changes.
module debounce_filter
  import count_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic level_rise,
  output logic level_fall
);

  localparam int unsigned DBW = cnt_width(DEBOUNCE_CYCLES + 1);

  if (!params_ok(DEBOUNCE_CYCLES, 1, 1)) begin : g_bad_params
    $error("debounce_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]     sync_q, sync_d;
  logic           btn_level_q, btn_level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_sync;

  assign btn_sync = sync_q[1];

  // Threshold is DEBOUNCE_CYCLES so the level lands DEBOUNCE_CYCLES+2 edges
  // after the raw pin is first sampled.
  always_comb begin
    sync_d      = {sync_q[0], btn_raw};
    btn_level_d = btn_level_q;
    db_cnt_d    = '0;
    if (btn_sync != btn_level_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES)) begin
        btn_level_d = ~btn_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      btn_level_q <= 1'b0;
      db_cnt_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      btn_level_q <= btn_level_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign level_rise = btn_level_d & ~btn_level_q;
  assign level_fall = ~btn_level_d & btn_level_q;

endmodule

// File: rtl/count_enable_conditioner.sv
// Turns a raw push-button into a clean count enable: one pulse per press,
// optional hold-to-auto-repeat, or debounced level pass-through.
module count_enable_conditioner
  import count_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  input  logic level_mode,
  output logic enable_out,
  output logic btn_level,
  output logic repeat_active
);

  localparam int unsigned TW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  if (!params_ok(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_bad_params
    $error("count_enable_conditioner: all parameters must be >= 1");
  end

  logic level_rise, level_fall;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .level_rise(level_rise),
    .level_fall(level_fall)
  );

  cond_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_q, pulse_d;
  logic          repeat_active_q;

  // Release is checked first so it overrides a coincident timer expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    if (level_fall) begin
      state_d = RELEASED;
      timer_d = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (level_rise) begin
            pulse_d = 1'b1;
            timer_d = DELAY_LOAD;
            state_d = HELD_WAIT;
          end
        end
        HELD_WAIT: begin
          if (!repeat_en) begin
            timer_d = DELAY_LOAD;
          end else if (timer_q == '0) begin
            pulse_d = 1'b1;
            timer_d = PERIOD_LOAD;
            state_d = REPEAT;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        REPEAT: begin
          if (!repeat_en) begin
            timer_d = DELAY_LOAD;
            state_d = HELD_WAIT;
          end else if (timer_q == '0) begin
            pulse_d = 1'b1;
            timer_d = PERIOD_LOAD;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RELEASED;
      timer_q         <= '0;
      pulse_q         <= 1'b0;
      repeat_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      pulse_q         <= pulse_d;
      repeat_active_q <= (state_d == REPEAT);
    end
  end

  assign enable_out    = level_mode ? btn_level : pulse_q;
  assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_count_enable_conditioner.sv
// Scenario bench for count_enable_conditioner with short debounce/repeat timing.
module tb_count_enable_conditioner;
  import count_cond_pkg::*;

  typedef struct packed {
    logic en;
    logic lvl;
    logic ra;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic repeat_en = 1'b0;
  logic level_mode = 1'b0;
  logic enable_out, btn_level, repeat_active;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  count_enable_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .repeat_en    (repeat_en),
    .level_mode   (level_mode),
    .enable_out   (enable_out),
    .btn_level    (btn_level),
    .repeat_active(repeat_active)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, queue the expectation, sample 1ns after the rising edge.
  task automatic drive_edge(input logic raw, input logic ren, input logic lm, input exp_t e);
    @(negedge clk);
    btn_raw    = raw;
    repeat_en  = ren;
    level_mode = lm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    level_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t got;
    @(negedge clk);
    rst_n = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {enable_out, btn_level, repeat_active};
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got en/lvl/ra=%b required 000", got);
    end
    checks++;
    if (dut.state_q !== RELEASED) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dut.state_q, RELEASED);
    end
    apply_reset();
  endtask

  task automatic test_clean_press();
    exp_t e, got;
    for (int k = 0; k < 48; k++) begin
      e.en = (k == 6);
      e.lvl = (k >= 6 && k < 46);
      e.ra = 1'b0;
      drive_edge(k < 40, 1'b0, 1'b0, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL clean_press edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
      if (k == 20) begin
        level_mode = 1'b1;
        #1;
        checks++;
        if (enable_out !== 1'b1) begin
          errors++;
          $display("FAIL mux_to_level edge %0d: got %b required 1", k, enable_out);
        end
        level_mode = 1'b0;
        #1;
        checks++;
        if (enable_out !== 1'b0) begin
          errors++;
          $display("FAIL mux_to_pulse edge %0d: got %b required 0", k, enable_out);
        end
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e, got;
    logic raw;
    for (int k = 0; k < 14; k++) begin
      raw = (k < 3) || (k == 4) || (k == 5);
      e = '0;
      drive_edge(raw, 1'b0, 1'b0, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL bounce edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
    end
    checks++;
    if (dut.u_debounce.db_cnt_q !== '0) begin
      errors++;
      $display("FAIL bounce_db_cnt: got %0d required 0", dut.u_debounce.db_cnt_q);
    end
  endtask

  task automatic test_auto_repeat();
    exp_t e, got;
    for (int k = 0; k < 41; k++) begin
      e.en = (k inside {6, 16, 19, 22, 25, 28, 31, 34});
      e.lvl = (k >= 6 && k < 36);
      e.ra = (k >= 16 && k < 36);
      drive_edge(k < 30, 1'b1, 1'b0, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL auto_repeat edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
    end
  endtask

  task automatic test_repeat_drop();
    exp_t e, got;
    for (int k = 0; k < 41; k++) begin
      e.en = (k inside {6, 16, 19});
      e.lvl = (k >= 6 && k < 36);
      e.ra = (k >= 16 && k < 20);
      drive_edge(k < 30, k < 20, 1'b0, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL repeat_drop edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
      if (k == 25) begin
        checks++;
        if (dut.state_q !== HELD_WAIT) begin
          errors++;
          $display("FAIL repeat_drop_state: got %0d required %0d", dut.state_q, HELD_WAIT);
        end
      end
    end
  endtask

  task automatic test_level_mode();
    exp_t e, got;
    for (int k = 0; k < 50; k++) begin
      e.lvl = (k >= 6 && k < 46);
      e.en = e.lvl;
      e.ra = 1'b0;
      drive_edge(k < 40, 1'b0, 1'b1, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL level_mode edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
    end
  endtask

  task automatic test_mid_hold_reset();
    exp_t e, got;
    for (int k = 0; k < 27; k++) begin
      if (k == 12) begin
        #2;
        rst_n = 1'b0;
        #1;
        got = {enable_out, btn_level, repeat_active};
        checks++;
        if (got !== 3'b000) begin
          errors++;
          $display("FAIL reset_async: got en/lvl/ra=%b required 000", got);
        end
      end
      if (k == 15) rst_n = 1'b1;
      e.en = (k == 6) || (k == 21);
      e.lvl = (k >= 6 && k < 12) || (k >= 21);
      e.ra = 1'b0;
      drive_edge(1'b1, 1'b0, 1'b0, e);
      got = {enable_out, btn_level, repeat_active};
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_hold_reset edge %0d: got en/lvl/ra=%b required %b", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    apply_reset();
    test_bounce();
    apply_reset();
    test_auto_repeat();
    apply_reset();
    test_repeat_drop();
    apply_reset();
    test_level_mode();
    apply_reset();
    test_mid_hold_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
